// File: rtl/des_pkg.sv
// DES key-schedule constants shared by the key schedule and the round datapath:
// permutation tables, per-round shift amounts, FSM states and round-key bank geometry.
package des_pkg;

  localparam int KEY_W      = 48;
  localparam int HALF_W     = 28;
  localparam int NUM_ROUNDS = 16;
  localparam int BANK_SLOTS = 8;
  localparam int BANK_W     = KEY_W * BANK_SLOTS;

  // Table entries use DES numbering: bit 1 is the most significant bit of the source.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFTS [NUM_ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic [1:0] {
    KS_IDLE = 2'd0,
    KS_GEN  = 2'd1,
    KS_DONE = 2'd2
  } ks_state_t;

  function automatic logic [55:0] apply_pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
    return cd;
  endfunction

  function automatic logic [KEY_W-1:0] apply_pc2(input logic [55:0] cd);
    logic [KEY_W-1:0] k;
    k = '0;
    for (int i = 0; i < KEY_W; i++) k[KEY_W-1-i] = cd[56-PC2[i]];
    return k;
  endfunction

  // Round r counts from 1.
  function automatic int shift_of(input int r);
    return SHIFTS[r-1];
  endfunction

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input int s);
    return (s == 2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  // Bit position of the least significant bit of a bank slot; slot 0 sits at the top.
  function automatic int slot_lsb(input int s);
    return BANK_W - KEY_W * (s + 1);
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Request/result bundle between a 3DES stage controller and its key schedule.
interface des_key_schedule_if;
  import des_pkg::*;

  logic              start;
  logic              decrypt;
  logic [63:0]       key;
  logic              busy;
  logic              keys_valid;
  logic [BANK_W-1:0] bank0_keys;
  logic [BANK_W-1:0] bank1_keys;

  modport master (
    output start, decrypt, key,
    input  busy, keys_valid, bank0_keys, bank1_keys
  );

  modport slave (
    input  start, decrypt, key,
    output busy, keys_valid, bank0_keys, bank1_keys
  );
endinterface

// File: rtl/des_key_schedule_key_pair_step.sv
// Combinational two-round step of the DES key schedule: produces Kj and Kj+1
// from the current C/D halves and hands back the twice-rotated halves.
module key_pair_step
  import des_pkg::*;
(
  input  logic [HALF_W-1:0] c,
  input  logic [HALF_W-1:0] d,
  input  logic [4:0]        j,
  output logic [KEY_W-1:0]  k_a,
  output logic [KEY_W-1:0]  k_b,
  output logic [HALF_W-1:0] c_next,
  output logic [HALF_W-1:0] d_next
);

  logic [HALF_W-1:0] c_a;
  logic [HALF_W-1:0] d_a;

  always_comb begin
    c_a    = rotl28(c, shift_of(int'(j)));
    d_a    = rotl28(d, shift_of(int'(j)));
    c_next = rotl28(c_a, shift_of(int'(j) + 1));
    d_next = rotl28(d_a, shift_of(int'(j) + 1));
    k_a    = apply_pc2({c_a, d_a});
    k_b    = apply_pc2({c_next, d_next});
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: two round keys per clock into a forward-ordered store,
// presented as two eight-key banks ordered for encrypt or decrypt.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  des_key_schedule_if.slave    ks
);

  ks_state_t         state;
  logic [2:0]        cnt;
  logic [HALF_W-1:0] c_q;
  logic [HALF_W-1:0] d_q;
  logic              dir_q;
  logic              busy_q;
  logic              valid_q;
  logic [KEY_W-1:0]  key_store [NUM_ROUNDS];

  logic [4:0]        j;
  logic [KEY_W-1:0]  k_a;
  logic [KEY_W-1:0]  k_b;
  logic [HALF_W-1:0] c_next;
  logic [HALF_W-1:0] d_next;
  logic [55:0]       cd_init;

  assign j       = {1'b0, cnt, 1'b1};
  assign cd_init = apply_pc1(ks.key);

  key_pair_step u_step (
    .c      (c_q),
    .d      (d_q),
    .j      (j),
    .k_a    (k_a),
    .k_b    (k_b),
    .c_next (c_next),
    .d_next (d_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= KS_IDLE;
      cnt     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_ROUNDS; i++) key_store[i] <= '0;
    end else begin
      case (state)
        KS_IDLE, KS_DONE: begin
          if (ks.start) begin
            state   <= KS_GEN;
            cnt     <= '0;
            c_q     <= cd_init[55:28];
            d_q     <= cd_init[27:0];
            dir_q   <= ks.decrypt;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            for (int i = 0; i < NUM_ROUNDS; i++) key_store[i] <= '0;
          end
        end
        KS_GEN: begin
          // Store index 2*cnt holds round key K(2*cnt+1).
          key_store[{cnt, 1'b0}] <= k_a;
          key_store[{cnt, 1'b1}] <= k_b;
          c_q <= c_next;
          d_q <= d_next;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state   <= KS_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state  <= KS_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ks.bank0_keys = '0;
    ks.bank1_keys = '0;
    if (valid_q) begin
      for (int s = 0; s < BANK_SLOTS; s++) begin
        if (dir_q) begin
          ks.bank0_keys[slot_lsb(s) +: KEY_W] = key_store[NUM_ROUNDS-1-s];
          ks.bank1_keys[slot_lsb(s) +: KEY_W] = key_store[BANK_SLOTS-1-s];
        end else begin
          ks.bank0_keys[slot_lsb(s) +: KEY_W] = key_store[s];
          ks.bank1_keys[slot_lsb(s) +: KEY_W] = key_store[BANK_SLOTS+s];
        end
      end
    end
  end

  assign ks.busy       = busy_q;
  assign ks.keys_valid = valid_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer, ordering, abort, restart and random keys
// against an independent bit-list model of the DES key schedule.
module tb_des_key_schedule;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  des_key_schedule_if ks_if ();

  des_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int SH_T [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Round key j (1..16): rotate the PC-1 halves by the cumulative shift, then PC-2.
  function automatic logic [47:0] ref_key(input logic [63:0] k, input int j);
    bit c [28];
    bit d [28];
    bit cd [56];
    int tot;
    logic [47:0] r;
    tot = 0;
    for (int i = 0; i < j; i++) tot += SH_T[i];
    for (int i = 0; i < 28; i++) begin
      c[i] = k[64-PC1_T[i]];
      d[i] = k[64-PC1_T[28+i]];
    end
    for (int i = 0; i < 28; i++) begin
      cd[i]    = c[(i + tot) % 28];
      cd[28+i] = d[(i + tot) % 28];
    end
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[PC2_T[i]-1];
    return r;
  endfunction

  // Round number expected in a bank slot for a given ordering.
  function automatic int exp_round(input int bank, input int s, input bit dec);
    if (bank == 0) return dec ? 16 - s : s + 1;
    return dec ? 8 - s : 9 + s;
  endfunction

  function automatic logic [47:0] slot_of(input logic [383:0] b, input int s);
    return b[383-48*s -: 48];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [63:0] k, input bit dec);
    ks_if.key     = k;
    ks_if.decrypt = dec;
    ks_if.start   = 1'b1;
    tick();
    ks_if.start   = 1'b0;
    ks_if.key     = $urandom();
    ks_if.decrypt = 1'(($urandom() >> 3) & 1);
  endtask

  // Counts busy samples from the start edge until keys_valid, bounded.
  task automatic wait_done(output int busy_cycles, output bit timed_out);
    busy_cycles = 0;
    timed_out   = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (ks_if.keys_valid) begin
        timed_out = 1'b0;
        break;
      end
      if (ks_if.busy) busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ks_if.start = 1'b0;
    ks_if.decrypt = 1'b0;
    ks_if.key = '0;
    tick();
    tick();
    total++;
    if ({ks_if.busy, ks_if.keys_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ctrl busy/valid=%b required 00", {ks_if.busy, ks_if.keys_valid});
    end
    total++;
    if ((ks_if.bank0_keys | ks_if.bank1_keys) !== '0) begin
      bad++;
      $display("FAIL reset_banks got nonzero bank required 0");
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_encrypt();
    int bc;
    bit to;
    pulse_start(64'h133457799BBCDFF1, 1'b0);
    wait_done(bc, to);
    total++;
    if (to || bc != 8) begin
      bad++;
      $display("FAIL fips_enc_latency busy=%0d timeout=%0d required 8/0", bc, to);
    end
    total++;
    if (slot_of(ks_if.bank0_keys, 0) !== 48'h1B02EFFC7072) begin
      bad++;
      $display("FAIL fips_enc_k1 got %h required 1b02effc7072", slot_of(ks_if.bank0_keys, 0));
    end
    total++;
    if (slot_of(ks_if.bank0_keys, 1) !== 48'h79AED9DBC9E5) begin
      bad++;
      $display("FAIL fips_enc_k2 got %h required 79aed9dbc9e5", slot_of(ks_if.bank0_keys, 1));
    end
    total++;
    if (slot_of(ks_if.bank1_keys, 7) !== 48'hCB3D8B0E17F5) begin
      bad++;
      $display("FAIL fips_enc_k16 got %h required cb3d8b0e17f5", slot_of(ks_if.bank1_keys, 7));
    end
  endtask

  task automatic test_fips_decrypt();
    int bc;
    bit to;
    pulse_start(64'h133457799BBCDFF1, 1'b1);
    wait_done(bc, to);
    total++;
    if (to || bc != 8) begin
      bad++;
      $display("FAIL fips_dec_latency busy=%0d timeout=%0d required 8/0", bc, to);
    end
    total++;
    if (slot_of(ks_if.bank0_keys, 0) !== 48'hCB3D8B0E17F5) begin
      bad++;
      $display("FAIL fips_dec_slot0 got %h required cb3d8b0e17f5", slot_of(ks_if.bank0_keys, 0));
    end
    total++;
    if (slot_of(ks_if.bank1_keys, 7) !== 48'h1B02EFFC7072) begin
      bad++;
      $display("FAIL fips_dec_b1s7 got %h required 1b02effc7072", slot_of(ks_if.bank1_keys, 7));
    end
    total++;
    if (slot_of(ks_if.bank1_keys, 6) !== 48'h79AED9DBC9E5) begin
      bad++;
      $display("FAIL fips_dec_b1s6 got %h required 79aed9dbc9e5", slot_of(ks_if.bank1_keys, 6));
    end
  endtask

  task automatic test_start_ignored();
    int bc;
    bit to;
    logic [63:0] k;
    k = 64'h133457799BBCDFF1;
    pulse_start(k, 1'b0);
    bc = 1;
    tick();
    tick();
    bc = 3;
    ks_if.key = 64'hDEADBEEF01234567;
    ks_if.decrypt = 1'b1;
    ks_if.start = 1'b1;
    tick();
    ks_if.start = 1'b0;
    wait_done(bc, to);
    total++;
    if (to || bc != 5) begin
      bad++;
      $display("FAIL ignored_start_timing remaining_busy=%0d timeout=%0d required 5/0", bc, to);
    end
    for (int s = 0; s < 8; s++) begin
      total++;
      if (slot_of(ks_if.bank0_keys, s) !== ref_key(k, s + 1) ||
          slot_of(ks_if.bank1_keys, s) !== ref_key(k, s + 9)) begin
        bad++;
        $display("FAIL ignored_start_slot%0d got %h/%h required %h/%h", s,
                 slot_of(ks_if.bank0_keys, s), slot_of(ks_if.bank1_keys, s),
                 ref_key(k, s + 1), ref_key(k, s + 9));
      end
    end
  endtask

  task automatic test_reset_mid_gen();
    int bc;
    bit to;
    logic [63:0] k;
    pulse_start(64'h0123456789ABCDEF, 1'b0);
    for (int n = 0; n < 4; n++) tick();
    rst = 1'b1;
    #1;
    total++;
    if ({ks_if.busy, ks_if.keys_valid} !== 2'b00 || (ks_if.bank0_keys | ks_if.bank1_keys) !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs busy/valid=%b required 00 with zero banks",
               {ks_if.busy, ks_if.keys_valid});
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (ks_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_idle busy=%b required 0", ks_if.busy);
    end
    k = 64'hFEDCBA9876543210;
    pulse_start(k, 1'b1);
    wait_done(bc, to);
    total++;
    if (to || bc != 8) begin
      bad++;
      $display("FAIL mid_reset_restart busy=%0d timeout=%0d required 8/0", bc, to);
    end
    for (int s = 0; s < 8; s++) begin
      total++;
      if (slot_of(ks_if.bank0_keys, s) !== ref_key(k, 16 - s)) begin
        bad++;
        $display("FAIL mid_reset_slot%0d got %h required %h", s,
                 slot_of(ks_if.bank0_keys, s), ref_key(k, 16 - s));
      end
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    int low;
    bit to;
    pulse_start(64'h0, 1'b0);
    total++;
    if (ks_if.keys_valid !== 1'b0 || ks_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart valid/busy=%b%b required 01", ks_if.keys_valid, ks_if.busy);
    end
    low = 0;
    bc = 0;
    to = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (ks_if.keys_valid) begin
        to = 1'b0;
        break;
      end
      low++;
      tick();
    end
    total++;
    if (to || low != 8) begin
      bad++;
      $display("FAIL b2b_valid_low cycles=%0d timeout=%0d required 8/0", low, to);
    end
    for (int s = 0; s < 8; s++) begin
      total++;
      if (slot_of(ks_if.bank0_keys, s) !== 48'h0 || slot_of(ks_if.bank1_keys, s) !== 48'h0) begin
        bad++;
        $display("FAIL b2b_zero_slot%0d got %h/%h required 0", s,
                 slot_of(ks_if.bank0_keys, s), slot_of(ks_if.bank1_keys, s));
      end
    end
  endtask

  task automatic test_random();
    int bc;
    bit to;
    bit dec;
    logic [63:0] k;
    logic [383:0] b0_hold;
    for (int it = 0; it < 120; it++) begin
      k   = {$urandom(), $urandom()};
      dec = 1'(it & 1);
      pulse_start(k, dec);
      wait_done(bc, to);
      total++;
      if (to || bc != 8) begin
        bad++;
        $display("FAIL rand%0d_busy busy=%0d timeout=%0d required 8/0", it, bc, to);
      end
      for (int s = 0; s < 8; s++) begin
        total++;
        if (slot_of(ks_if.bank0_keys, s) !== ref_key(k, exp_round(0, s, dec))) begin
          bad++;
          $display("FAIL rand%0d_b0s%0d got %h required %h", it, s,
                   slot_of(ks_if.bank0_keys, s), ref_key(k, exp_round(0, s, dec)));
        end
        total++;
        if (slot_of(ks_if.bank1_keys, s) !== ref_key(k, exp_round(1, s, dec))) begin
          bad++;
          $display("FAIL rand%0d_b1s%0d got %h required %h", it, s,
                   slot_of(ks_if.bank1_keys, s), ref_key(k, exp_round(1, s, dec)));
        end
      end
      b0_hold = ks_if.bank0_keys;
      tick();
      total++;
      if (ks_if.keys_valid !== 1'b1 || ks_if.bank0_keys !== b0_hold) begin
        bad++;
        $display("FAIL rand%0d_hold valid=%b required 1 with stable bank0", it, ks_if.keys_valid);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fips_encrypt();
    test_fips_decrypt();
    test_start_ignored();
    test_reset_mid_gen();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Generates the sixteen 48-bit DES round keys from a 64-bit key and presents them as two 384-bit eight-key banks in the round-key bus format that the two-rounds-per-cycle DES datapath consumes. The schedule produces two round keys per clock, so one full schedule takes 8 cycles. In decrypt mode the same keys are presented in reverse order. Each of the three DES stages of the 3DES pipeline has one instance, loaded once per key change.

## Interface
- No parameters; all widths are fixed by DES.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; latches `key` and `decrypt`.
- decrypt  in  1  0 = encrypt ordering, 1 = decrypt ordering.
- key  in  64  DES key; bit 63 is DES bit 1, parity bits ignored.
- busy  out  1  schedule generation in progress.
- keys_valid  out  1  both banks hold a complete schedule (level).
- bank0_keys  out  384  first eight round keys.
- bank1_keys  out  384  last eight round keys.

## Operation
- Bank layout:
  - Slot 0 (first round applied) is bits [383:336]; slot 7 is bits [47:0].
  - Encrypt: bank0 = K1..K8, bank1 = K9..K16.
  - Decrypt: bank0 = K16..K9, bank1 = K8..K1.
- States:
  - IDLE: `start` moves to GEN.
  - GEN: count 0..7, two keys per count. At count 7, moves to DONE.
  - DONE: behaves as IDLE but `keys_valid` = 1.
- On accepted `start`:
  - PC-1(key) loads into the 28-bit C/D registers.
  - `decrypt` is latched into `dir_q`.
  - The key store and `keys_valid` are cleared.
  - count = 0.
- Each GEN cycle computes two rounds, j = 2·count+1 and j+1:
  - Rotate C/D left by shift(j), apply PC-2 to get Kj.
  - Rotate again by shift(j+1), apply PC-2 to get Kj+1.
  - Store both keys; C/D register takes the second rotated value.
- Shift schedule for rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (total 28; C/D returns to PC-1 value).
- Keys are always stored internally in forward order (768-bit store). Bank ordering is a combinational permutation selected by `dir_q`.
- `start` while `busy` = 1 is ignored: no restart, and the latched key is unchanged.
- `start` in DONE is accepted and restarts the schedule.
- `decrypt` and `key` changing outside a `start` cycle have no effect.
- Banks read all-zero whenever `keys_valid` = 0.

## Timing
- Reset values:
  - State IDLE, count 0, C/D 0, store 0.
  - `busy` = 0, `keys_valid` = 0, both banks 0.
- Reset mid-GEN aborts immediately. No partial keys are visible afterwards.
- `start` sampled at edge E0: `busy` = 1 after E0.
- Keys K(2n+1), K(2n+2) are written at edge E(n+1).
- After E8: `busy` = 0 and `keys_valid` = 1. Latency is 8 cycles from the `start` edge.
- Back-to-back: `start` in the first DONE cycle gives `keys_valid` = 0 after that edge, and a new result 8 edges later.
- Downstream must not assert its enable until `keys_valid` = 1. Banks are stable while `keys_valid` = 1.

## Structure
- Shared package `des_pkg`:
  - PC1 and PC2 permutation tables.
  - 16-entry shift schedule constant.
  - State enum `ks_state_t`.
  - Bank-slot width/index constants (48-bit key, 8 slots), shared with the round datapath.
- Sub-module `key_pair_step` (combinational):
  - Inputs: C, D, round index j.
  - Outputs: Kj, Kj+1, next C/D.
- Top level holds the FSM, count, C/D registers, key store and bank permutation.

## Test plan
- FIPS example, encrypt:
  - Stimulus: key 0x133457799BBCDFF1, decrypt = 0, `start`.
  - Response: 8 cycles later `keys_valid` = 1.
  - bank0[383:336] = 0x1B02EFFC7072, bank0[335:288] = 0x79AED9DBC9E5, bank1[47:0] = 0xCB3D8B0E17F5.
- Same key, decrypt = 1:
  - bank0[383:336] = 0xCB3D8B0E17F5, bank1[47:0] = 0x1B02EFFC7072, bank1[95:48] = 0x79AED9DBC9E5.
- `start` pulsed again at cycle 3 of GEN with a different key:
  - The pulse is ignored.
  - The result matches test 1 and completes at the original cycle.
- `rst` asserted at GEN cycle 5:
  - All outputs 0 immediately; state IDLE.
  - A subsequent `start` produces a correct schedule.
- `start` in DONE with key 0x0000000000000000:
  - `keys_valid` drops for 8 cycles.
  - All 16 keys = 0x000000000000.
- Random keys (≥100), both directions:
  - Compare all 16 slots against a reference-model key schedule.
  - Check `busy` is high for exactly 8 cycles.
